// File: rtl/regs_shadow.sv
// regs_shadow: banked register file with interrupt-driven shadow bank switching
//
// Ports:
//   clk         - clock, all state changes on rising edge
//   rst         - asynchronous active-low reset; clears every bank, cur_bank and bank_err
//   wt          - write enable
//   reg_wt_addr - write address within the active bank
//   Data_in     - write data
//   reg_addr_A  - read address, port A
//   reg_addr_B  - read address, port B
//   int_enter   - switch to the next bank up
//   int_exit    - switch to the next bank down
//   rdata_A     - combinational read data, port A
//   rdata_B     - combinational read data, port B
//   cur_bank    - active bank index (registered)
//   bank_err    - sticky flag: enter at top bank or exit at bottom bank
//
// Macro REGS_SHADOW_BYPASS_EN: when defined, a write to a nonzero address is
// forwarded to any read port addressing it in the same cycle.
module regs_shadow #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BANKS  = 2,
    localparam int BANK_W = (BANKS > 2) ? $clog2(BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wt,
    input  logic [ADDR_W-1:0] reg_wt_addr,
    input  logic [DATA_W-1:0] Data_in,
    input  logic [ADDR_W-1:0] reg_addr_A,
    input  logic [ADDR_W-1:0] reg_addr_B,
    input  logic              int_enter,
    input  logic              int_exit,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic [BANK_W-1:0] cur_bank,
    output logic              bank_err
);

    logic [DATA_W-1:0] mem_q [BANKS][2**ADDR_W];
    logic [BANK_W-1:0] cur_bank_q, cur_bank_d;
    logic              bank_err_q, bank_err_d;
    logic              enter, leave, at_top, at_bot, wr_en;

    // Simultaneous enter and exit cancel each other out.
    assign enter  = int_enter & ~int_exit;
    assign leave  = int_exit & ~int_enter;
    assign at_top = cur_bank_q == BANK_W'(BANKS - 1);
    assign at_bot = cur_bank_q == '0;
    assign wr_en  = wt && reg_wt_addr != '0;

    always_comb begin
        cur_bank_d = enter && !at_top ? cur_bank_q + BANK_W'(1) :
                     leave && !at_bot ? cur_bank_q - BANK_W'(1) : cur_bank_q;
        bank_err_d = bank_err_q | (enter & at_top) | (leave & at_bot);
    end

    // The write uses cur_bank_q, so a write coincident with a switch lands in
    // the bank that was active before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < BANKS; b++)
                for (int a = 0; a < 2**ADDR_W; a++)
                    mem_q[b][a] <= '0;
            cur_bank_q <= '0;
            bank_err_q <= 1'b0;
        end else begin
            if (wr_en)
                mem_q[cur_bank_q][reg_wt_addr] <= Data_in;
            cur_bank_q <= cur_bank_d;
            bank_err_q <= bank_err_d;
        end
    end

    always_comb begin
`ifdef REGS_SHADOW_BYPASS_EN
        // Forwarding is gated by rst so reads stay zero while in reset.
        rdata_A = reg_addr_A == '0 ? '0 :
                  rst && wr_en && reg_addr_A == reg_wt_addr ? Data_in : mem_q[cur_bank_q][reg_addr_A];
        rdata_B = reg_addr_B == '0 ? '0 :
                  rst && wr_en && reg_addr_B == reg_wt_addr ? Data_in : mem_q[cur_bank_q][reg_addr_B];
`else
        rdata_A = reg_addr_A == '0 ? '0 : mem_q[cur_bank_q][reg_addr_A];
        rdata_B = reg_addr_B == '0 ? '0 : mem_q[cur_bank_q][reg_addr_B];
`endif
    end

    assign cur_bank = cur_bank_q;
    assign bank_err = bank_err_q;

endmodule
